toggle_period_meter: RTL and testbench
======================================

# toggle_period_meter

Receive-side counterpart to the team's clock dividers: takes a slow, asynchronous toggling signal (e.g. a divided game tick), synchronizes it, and emits a one-cycle pulse per toggle. It also measures the interval between consecutive toggles in system clocks and delivers each measurement over a valid/ready handshake. A watchdog flags a stalled divider. It sits between divider outputs and game logic that needs tick events or rate checks.

## Interface
- CNT_W, 28, width of interval counter and `period` output
- TIMEOUT, 28'hFFFFFFF, cycles without a toggle before `timeout` asserts; legal range 2..2^CNT_W-1
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- tog_in  input  1  asynchronous toggling input; both edges are events
- period_ready  input  1  consumer accepts `period`
- edge_pulse  output  1  one-cycle pulse per detected toggle
- period  output  CNT_W  clk cycles between the last two detected toggles
- period_valid  output  1  `period` holds an unconsumed measurement
- overrun  output  1  sticky; a measurement overwrote an unconsumed one
- timeout  output  1  no toggle for TIMEOUT cycles
- locked  output  1  measurements currently trustworthy

## Operation
- Synchronizer: s1 <= tog_in, s2 <= s1, s3 <= s2. Internal det = s2 ^ s3. `edge_pulse` is a registered copy of det.
- Counter cnt (CNT_W bits):
  - cleared to 0 in the cycle det is high;
  - otherwise increments by 1, saturating at TIMEOUT-1.
  - A measured interval of N cycles therefore appears as cnt = N-1 at the next det, and `period` is loaded with cnt+1.
- States:
  - IDLE: after reset. On det, go to MEASURE with no capture.
  - MEASURE:
    - On det, capture `period` = cnt+1, set `period_valid`, set `locked`.
    - If there is no det and cnt == TIMEOUT-1, go to TOUT.
  - TOUT: `timeout` = 1 and `locked` = 0. On det, go to MEASURE, clear `timeout`, no capture.
- Handshake:
  - `period_valid` clears on a clock edge where valid and ready are both high and there is no capture.
  - Capture in the same cycle as an accept: new value loaded, valid stays 1, overrun unchanged.
  - Capture while valid=1 and ready=0: `period` overwritten with the newest value, valid stays 1, `overrun` set.
  - `overrun` clears only on rst.
- `locked`:
  - rises with the first capture;
  - falls on entry to TOUT and on rst.
- Reset:
  - all outputs 0; s1..s3 = 0; cnt = 0; state IDLE.
  - Any in-flight or pending measurement is discarded.
- If tog_in = 1 at reset release, the 0->1 transition through the synchronizer is a legitimate det. It yields one `edge_pulse` and only moves IDLE->MEASURE, so no bogus period is produced.

## Timing
- tog_in first sampled at its new level on clk edge k:
  - det is high after edge k+2;
  - `edge_pulse` is high for exactly the cycle after edge k+3.
- `period`, `period_valid` and `locked` update on the same edge that registers `edge_pulse` (edge k+3). There are no combinational paths from inputs to outputs.
- `timeout` rises exactly TIMEOUT cycles after the cycle in which det was last high.
- Interval resolution is 1 clk cycle. Synchronizer jitter is at most ±1 cycle per measurement for a truly asynchronous tog_in.
- Intervals ≥ TIMEOUT are never reported; they always produce TOUT.
- Minimum measurable interval is 1 (det on consecutive cycles gives `period` = 1).

## Test plan
Bench parameters: CNT_W=8, TIMEOUT=20.

- **Steady toggling:** rst 2 cycles, tog_in=0, then toggle every 6 cycles, period_ready=1 -> one `edge_pulse` per toggle, 3 cycles after each toggle is sampled. Second pulse brings `period`=6, `period_valid`=1 for one cycle, `locked`=1; all later captures are 6.
- **Overrun:** period_ready=0, toggle every 6 then every 7 -> `period`=7 (latest), `period_valid`=1, `overrun`=1. One ready cycle clears valid; `overrun` stays 1 until rst.
- **Capture and accept in the same cycle:** ready high on the capture edge with valid already 1 -> new value loaded, valid stays 1, `overrun`=0.
- **Timeout and recovery:** stop toggling after a lock -> `timeout`=1 and `locked`=0 exactly 20 cycles after the last det. Resume toggling every 5 -> first pulse clears `timeout` with no capture; second pulse gives `period`=5 and `locked`=1.
- **Reset mid-operation:** assert rst mid-interval with `period_valid`=1 -> next cycle all outputs 0. The next toggle produces `edge_pulse` only, no `period_valid`.
- **tog_in high at reset release:** hold tog_in=1 through reset -> exactly one `edge_pulse`, no `period_valid`. The next toggle 9 cycles later yields `period`=9.

Source files
------------

// File: rtl/toggle_period_meter.sv
// rtl/toggle_period_meter.sv - toggle synchronizer, edge pulser and toggle-interval meter
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   tog_in        asynchronous toggling input; both edges are events
//   period_ready  consumer accepts the current period measurement
//   edge_pulse    one-cycle pulse per detected toggle
//   period        clk cycles between the last two detected toggles
//   period_valid  period holds an unconsumed measurement
//   overrun       sticky; a measurement replaced an unconsumed one
//   timeout       no toggle seen for TIMEOUT cycles
//   locked        measurements currently trustworthy

module toggle_period_meter #(
   parameter int               CNT_W   = 28,
   parameter logic [CNT_W-1:0] TIMEOUT = 28'hFFFFFFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tog_in,
   input  logic             period_ready,
   output logic             edge_pulse,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             overrun,
   output logic             timeout,
   output logic             locked
);

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = TIMEOUT - ONE;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEAS,
      S_TOUT
   } state_t;

   state_t           state;
   logic             s1, s2, s3;
   logic             det;
   logic [CNT_W-1:0] cnt;
   logic             sat;
   logic             capture;

   // A saturated counter means at least TIMEOUT cycles have elapsed since
   // the previous toggle, so that interval is never reported.
   assign sat     = (cnt == CNT_MAX);
   assign capture = det && (state == S_MEAS) && !sat;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1           <= 1'b0;
         s2           <= 1'b0;
         s3           <= 1'b0;
         det          <= 1'b0;
         cnt          <= '0;
         state        <= S_IDLE;
         edge_pulse   <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         overrun      <= 1'b0;
         timeout      <= 1'b0;
         locked       <= 1'b0;
      end else begin
         // s1/s2 form the metastability guard; det is registered so that
         // edge_pulse and the capture land on the same edge.
         s1         <= tog_in;
         s2         <= s1;
         s3         <= s2;
         det        <= s2 ^ s3;
         edge_pulse <= det;

         if (det) begin
            cnt <= '0;
         end else if (!sat) begin
            cnt <= cnt + ONE;
         end

         case (state)
            S_IDLE: begin
               // First toggle only establishes a time reference.
               if (det) begin
                  state <= S_MEAS;
               end
            end
            S_MEAS: begin
               // Saturation wins over a coincident toggle: an interval of
               // TIMEOUT cycles is a stall, not a measurement.
               if (sat) begin
                  state   <= S_TOUT;
                  timeout <= 1'b1;
                  locked  <= 1'b0;
               end else if (det) begin
                  locked <= 1'b1;
               end
            end
            S_TOUT: begin
               if (det) begin
                  state   <= S_MEAS;
                  timeout <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         if (capture) begin
            period       <= cnt + ONE;
            period_valid <= 1'b1;
            if (period_valid && !period_ready) begin
               overrun <= 1'b1;
            end
         end else if (period_valid && period_ready) begin
            period_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_toggle_period_meter.sv
// tb/tb_toggle_period_meter.sv - self-checking bench for toggle_period_meter

module tb_toggle_period_meter;

   localparam int CNT_W = 8;
   localparam int TO    = 20;

   logic             clk = 1'b0;
   logic             rst;
   logic             tog_in;
   logic             period_ready;
   logic             edge_pulse;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             overrun;
   logic             timeout;
   logic             locked;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   toggle_period_meter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (8'd20)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .tog_in       (tog_in),
      .period_ready (period_ready),
      .edge_pulse   (edge_pulse),
      .period       (period),
      .period_valid (period_valid),
      .overrun      (overrun),
      .timeout      (timeout),
      .locked       (locked)
   );

   // Reference model: works on absolute edge timestamps. A level change
   // sampled at edge k is a detection at time k+2, reported at edge k+3.
   // Intervals are differences of detection times.
   int         ecnt = 0;
   int         pend[$];
   bit         m_prev;
   int         m_state;   // 0 idle, 1 measuring, 2 timed out
   int         m_last;
   bit         m_en = 1'b0;
   logic       e_pulse, e_valid, e_ov, e_to, e_lock;
   logic [7:0] e_period;

   always @(posedge clk) begin
      bit capd;
      int iv;
      ecnt++;
      if (rst) begin
         pend.delete();
         m_prev   = 1'b0;
         m_state  = 0;
         m_last   = 0;
         e_pulse  = 1'b0;
         e_valid  = 1'b0;
         e_ov     = 1'b0;
         e_to     = 1'b0;
         e_lock   = 1'b0;
         e_period = '0;
         m_en     = 1'b1;
      end else begin
         capd    = 1'b0;
         e_pulse = 1'b0;
         if (pend.size() > 0 && pend[0] == ecnt - 1) begin
            void'(pend.pop_front());
            e_pulse = 1'b1;
            if (m_state == 0) begin
               m_state = 1;
            end else if (m_state == 1) begin
               iv = (ecnt - 1) - m_last;
               if (iv < TO) begin
                  if (e_valid && !period_ready) e_ov = 1'b1;
                  e_period = 8'(iv);
                  e_valid  = 1'b1;
                  e_lock   = 1'b1;
                  capd     = 1'b1;
               end else begin
                  m_state = 2;
                  e_to    = 1'b1;
                  e_lock  = 1'b0;
               end
            end else begin
               m_state = 1;
               e_to    = 1'b0;
            end
            m_last = ecnt - 1;
         end else if (m_state == 1 && (ecnt - 1) - m_last == TO) begin
            m_state = 2;
            e_to    = 1'b1;
            e_lock  = 1'b0;
         end
         if (!capd && e_valid && period_ready) e_valid = 1'b0;
         if (tog_in !== m_prev) begin
            pend.push_back(ecnt + 2);
            m_prev = tog_in;
         end
      end
   end

   always @(negedge clk) begin
      if (m_en) begin
         tests++;
         if ({edge_pulse, period, period_valid, overrun, timeout, locked} !==
             {e_pulse, e_period, e_valid, e_ov, e_to, e_lock}) begin
            fails++;
            $display("FAIL model edge=%0d got pulse=%b period=%0d valid=%b ov=%b to=%b lock=%b, exp pulse=%b period=%0d valid=%b ov=%b to=%b lock=%b",
                     ecnt, edge_pulse, period, period_valid, overrun, timeout, locked,
                     e_pulse, e_period, e_valid, e_ov, e_to, e_lock);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      bit         rdy;
      bit         rdy_cap;
      int         gap;
      logic [7:0] exp_period;
      bit         exp_valid;
      bit         exp_ov;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int gap;

      vecs[0] = '{rdy: 1'b0, rdy_cap: 1'b0, gap: 6, exp_period: 8'd6, exp_valid: 1'b1, exp_ov: 1'b0};
      vecs[1] = '{rdy: 1'b0, rdy_cap: 1'b1, gap: 8, exp_period: 8'd6, exp_valid: 1'b1, exp_ov: 1'b0};
      vecs[2] = '{rdy: 1'b0, rdy_cap: 1'b0, gap: 7, exp_period: 8'd8, exp_valid: 1'b1, exp_ov: 1'b1};
      vecs[3] = '{rdy: 1'b0, rdy_cap: 1'b0, gap: 7, exp_period: 8'd7, exp_valid: 1'b1, exp_ov: 1'b1};

      rst          = 1'b1;
      tog_in       = 1'b0;
      period_ready = 1'b1;
      step(2);
      chk1("reset pulse", edge_pulse, 1'b0);
      chk8("reset period", period, 8'd0);
      chk1("reset valid", period_valid, 1'b0);
      chk1("reset locked", locked, 1'b0);
      rst = 1'b0;
      step(2);

      // Steady toggling every 6 cycles.
      for (int i = 0; i < 5; i++) begin
         tog_in = ~tog_in;
         step(4);
         chk1("steady pulse", edge_pulse, 1'b1);
         if (i == 0) begin
            chk1("first toggle no valid", period_valid, 1'b0);
            chk1("first toggle no lock", locked, 1'b0);
         end else begin
            chk8("steady period", period, 8'd6);
            chk1("steady valid", period_valid, 1'b1);
            chk1("steady locked", locked, 1'b1);
         end
         step(1);
         chk1("steady pulse low", edge_pulse, 1'b0);
         chk1("steady accepted", period_valid, 1'b0);
         step(1);
      end

      // Same-cycle accept, then overrun.
      for (int i = 0; i < 4; i++) begin
         period_ready = vecs[i].rdy;
         tog_in = ~tog_in;
         step(3);
         period_ready = vecs[i].rdy_cap;
         step(1);
         chk8("vec period", period, vecs[i].exp_period);
         chk1("vec valid", period_valid, vecs[i].exp_valid);
         chk1("vec overrun", overrun, vecs[i].exp_ov);
         period_ready = vecs[i].rdy;
         step(vecs[i].gap - 4);
      end
      period_ready = 1'b1;
      step(1);
      chk1("overrun accept clears valid", period_valid, 1'b0);
      chk1("overrun sticky", overrun, 1'b1);
      period_ready = 1'b0;

      // Timeout: last detection at k+2, timeout registered at edge k+23.
      step(15);
      chk1("pre-timeout", timeout, 1'b0);
      chk1("pre-timeout locked", locked, 1'b1);
      step(1);
      chk1("timeout", timeout, 1'b1);
      chk1("timeout unlocks", locked, 1'b0);

      // Recovery at 5-cycle interval.
      period_ready = 1'b1;
      tog_in = ~tog_in;
      step(4);
      chk1("recover pulse", edge_pulse, 1'b1);
      chk1("recover timeout cleared", timeout, 1'b0);
      chk1("recover no capture", period_valid, 1'b0);
      step(1);
      tog_in = ~tog_in;
      step(4);
      chk8("recover period", period, 8'd5);
      chk1("recover valid", period_valid, 1'b1);
      chk1("recover locked", locked, 1'b1);
      period_ready = 1'b0;
      step(1);
      chk1("held valid", period_valid, 1'b1);

      // Reset mid-operation.
      rst    = 1'b1;
      tog_in = 1'b0;
      step(1);
      chk1("midrst pulse", edge_pulse, 1'b0);
      chk8("midrst period", period, 8'd0);
      chk1("midrst valid", period_valid, 1'b0);
      chk1("midrst overrun", overrun, 1'b0);
      chk1("midrst timeout", timeout, 1'b0);
      chk1("midrst locked", locked, 1'b0);
      rst = 1'b0;
      step(3);
      tog_in = 1'b1;
      step(4);
      chk1("post-rst pulse", edge_pulse, 1'b1);
      chk1("post-rst no valid", period_valid, 1'b0);
      step(1);

      // tog_in high at reset release.
      rst = 1'b1;
      period_ready = 1'b1;
      step(2);
      rst = 1'b0;
      step(4);
      chk1("high-release pulse", edge_pulse, 1'b1);
      chk1("high-release no valid", period_valid, 1'b0);
      step(5);
      tog_in = 1'b0;
      step(4);
      chk8("high-release period", period, 8'd9);
      chk1("high-release valid", period_valid, 1'b1);

      // Randomized intervals, ready and occasional reset; model checks each cycle.
      for (int s = 0; s < 250; s++) begin
         gap = $urandom_range(1, 24);
         for (int c = 0; c < gap; c++) begin
            period_ready = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 149) == 0);
            step(1);
         end
         rst = 1'b0;
         tog_in = ~tog_in;
      end
      step(30);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
